// File: rtl/display_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver: double-buffered value, frame-synchronous
// updates, inter-digit blanking and leading-zero suppression. All outputs are registered.
module display_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [15:0] Value,
  input  logic [3:0]  Dp_In,
  input  logic        Load,
  input  logic        Blank_Lead,
  input  logic [3:0]  Digit_En,
  output logic [3:0]  Nibble,
  output logic [3:0]  An,
  output logic        Dp,
  output logic [1:0]  Digit_Idx,
  output logic        Frame_Tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_START = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   pend_val_reg, pend_val_next;
  logic [3:0]    pend_dp_reg, pend_dp_next;
  logic          pend_v_reg, pend_v_next;
  logic [15:0]   disp_val_reg, disp_val_next;
  logic [3:0]    disp_dp_reg, disp_dp_next;
  logic [3:0]    nibble_reg, nibble_next;
  logic [3:0]    an_reg, an_next;
  logic          dp_reg, dp_next;
  logic          tick_reg, tick_next;

  logic          terminal;
  logic          boundary;
  logic          digit_on;
  logic [3:1]    nib_zero;
  logic [3:1]    lead_zero;
  logic [3:0]    supp;

  // Scan timing and double buffer
  always_comb begin
    terminal      = (cnt_reg == CNT_LAST);
    boundary      = terminal && (idx_reg == 2'd0);
    cnt_next      = terminal ? '0 : cnt_reg + 1'b1;
    idx_next      = terminal ? idx_reg - 2'd1 : idx_reg;
    pend_val_next = Load ? Value : pend_val_reg;
    pend_dp_next  = Load ? Dp_In : pend_dp_reg;
    pend_v_next   = boundary ? 1'b0 : (Load ? 1'b1 : pend_v_reg);
    disp_val_next = disp_val_reg;
    disp_dp_next  = disp_dp_reg;
    // A load landing on the boundary bypasses the pending buffer so the newest value wins
    if (boundary && Load) begin
      disp_val_next = Value;
      disp_dp_next  = Dp_In;
    end else if (boundary && pend_v_reg) begin
      disp_val_next = pend_val_reg;
      disp_dp_next  = pend_dp_reg;
    end
  end

  // A digit is a leading zero only if it and every digit to its left are zero
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_supp
      assign nib_zero[gi]  = (disp_val_next[gi*4 +: 4] == 4'h0);
      assign lead_zero[gi] = &nib_zero[3:gi];
      assign supp[gi]      = Blank_Lead && lead_zero[gi] && !disp_dp_next[gi];
    end
  endgenerate
  assign supp[0] = 1'b0;

  // Outputs are precomputed from next-state values so they line up with cnt/Digit_Idx
  always_comb begin
    digit_on    = (cnt_next >= BLANK_START) && Digit_En[idx_next] && !supp[idx_next];
    an_next     = digit_on ? ~(4'b0001 << idx_next) : 4'b1111;
    dp_next     = digit_on ? ~disp_dp_next[idx_next] : 1'b1;
    nibble_next = disp_val_next[{idx_next, 2'b00} +: 4];
    tick_next   = boundary;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_reg      <= '0;
      idx_reg      <= 2'd3;
      pend_val_reg <= '0;
      pend_dp_reg  <= '0;
      pend_v_reg   <= 1'b0;
      disp_val_reg <= '0;
      disp_dp_reg  <= '0;
      nibble_reg   <= '0;
      an_reg       <= 4'b1111;
      dp_reg       <= 1'b1;
      tick_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      pend_val_reg <= pend_val_next;
      pend_dp_reg  <= pend_dp_next;
      pend_v_reg   <= pend_v_next;
      disp_val_reg <= disp_val_next;
      disp_dp_reg  <= disp_dp_next;
      nibble_reg   <= nibble_next;
      an_reg       <= an_next;
      dp_reg       <= dp_next;
      tick_reg     <= tick_next;
    end
  end

  assign Nibble     = nibble_reg;
  assign An         = an_reg;
  assign Dp         = dp_reg;
  assign Digit_Idx  = idx_reg;
  assign Frame_Tick = tick_reg;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: per-cycle expected outputs are queued by the
// stimulus process and popped/compared by a negedge monitor.
module tb_display_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lead = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  display_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .Clk(clk), .Rst_n(rst_n), .Value(value), .Dp_In(dp_in), .Load(load),
    .Blank_Lead(blank_lead), .Digit_En(digit_en), .Nibble(nibble), .An(an),
    .Dp(dp), .Digit_Idx(digit_idx), .Frame_Tick(frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] nib;
    logic       dp;
    logic       tick;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int base = 0;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || an !== e.an || nibble !== e.nib || dp !== e.dp ||
          frame_tick !== e.tick || digit_idx !== e.idx) begin
        errors++;
        $display("FAIL scan cyc=%0d (want cyc=%0d) got an=%b nib=%h dp=%b tick=%b idx=%0d required an=%b nib=%h dp=%b tick=%b idx=%0d",
                 cyc, e.cyc, an, nibble, dp, frame_tick, digit_idx, e.an, e.nib, e.dp, e.tick, e.idx);
      end else begin
        $display("check cyc=%0d an=%b nib=%h dp=%b tick=%b idx=%0d ok",
                 cyc, an, nibble, dp, frame_tick, digit_idx);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int r);
    while (cyc < base + r) step();
  endtask

  task automatic do_load(input int r, input logic [15:0] v, input logic [3:0] d);
    wait_rel(r);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic push(input int c, input logic [3:0] a, input logic [3:0] n,
                      input logic d, input logic t, input logic [1:0] i);
    exp_t e;
    e.cyc = c; e.an = a; e.nib = n; e.dp = d; e.tick = t; e.idx = i;
    q.push_back(e);
  endtask

  // One slot: anode off for BC cycles, then on (if lit) with the given Dp level
  task automatic push_slot(input int rel, input int s, input logic [15:0] val,
                           input logic lit, input logic dpl, input logic tick, input int ncyc);
    logic [3:0] onehot_low;
    logic       on;
    onehot_low = ~(4'b0001 << s);
    for (int k = 0; k < ncyc; k++) begin
      on = lit && (k >= BC);
      push(base + rel + k, on ? onehot_low : 4'b1111, val[s*4 +: 4],
           on ? dpl : 1'b1, tick && (k == 0), 2'(s));
    end
  endtask

  task automatic push_frame(input int rel, input logic [15:0] val, input logic [3:0] lit,
                            input logic [3:0] dpl, input logic tick);
    for (int s = 3; s >= 0; s--)
      push_slot(rel + (3 - s) * RD, s, val, lit[s], dpl[s], tick && (s == 3), RD);
  endtask

  initial begin
    push(1, 4'b1111, 4'h0, 1'b1, 1'b0, 2'd3);
    push(2, 4'b1111, 4'h0, 1'b1, 1'b0, 2'd3);
    step(); step(); step();
    rst_n = 1'b1;
    base = cyc;

    push_frame(0,   16'h0000, 4'b1111, 4'b1111, 1'b0);
    push_frame(32,  16'h1234, 4'b1111, 4'b1111, 1'b1);
    push_frame(64,  16'hABCD, 4'b1111, 4'b1111, 1'b1);
    push_frame(96,  16'h00F0, 4'b1111, 4'b1111, 1'b1);
    push_frame(128, 16'h2222, 4'b1111, 4'b1111, 1'b1);
    push_frame(160, 16'h0005, 4'b0001, 4'b1111, 1'b1);
    push_frame(192, 16'h0005, 4'b0101, 4'b1011, 1'b1);
    push_slot(224, 3, 16'h1234, 1'b0, 1'b1, 1'b1, RD);
    push_slot(232, 2, 16'h1234, 1'b1, 1'b1, 1'b0, RD);
    push_slot(240, 1, 16'h1234, 1'b0, 1'b1, 1'b0, 5);
    for (int k = 245; k < 248; k++) push(base + k, 4'b1111, 4'h0, 1'b1, 1'b0, 2'd3);
    push_frame(248, 16'h0000, 4'b1111, 4'b1111, 1'b0);
    push_frame(280, 16'h0000, 4'b1111, 4'b1111, 1'b1);

    do_load(0,   16'h1234, 4'b0000);
    do_load(43,  16'hABCD, 4'b0000);
    do_load(95,  16'h00F0, 4'b0000);
    do_load(100, 16'h1111, 4'b0000);
    do_load(110, 16'h2222, 4'b0000);
    wait_rel(130);
    blank_lead = 1'b1;
    do_load(130, 16'h0005, 4'b0000);
    do_load(170, 16'h0005, 4'b0100);
    do_load(200, 16'h1234, 4'b0000);
    wait_rel(220);
    digit_en   = 4'b0101;
    blank_lead = 1'b0;
    do_load(230, 16'h9999, 4'b0000);
    wait_rel(245);
    digit_en = 4'b1111;
    rst_n    = 1'b0;
    wait_rel(248);
    rst_n = 1'b1;
    wait_rel(316);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Time-multiplexed scan driver for the board's 4-digit common-anode 7-segment display. Holds a 16-bit value, rotates through its four hex nibbles, and presents one nibble per slot to the hex-to-segment decoder. It also drives the active-low digit anodes and the decimal point, with inter-digit blanking, leading-zero suppression and tear-free frame-synchronous updates. It sits directly upstream of the segment decoder: `Nibble[3:0]` feeds the decoder's `In3..In0`.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot. Must be ≥ 2. Default gives 1 kHz slot rate and 250 Hz frame rate at 50 MHz.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off (anti-ghosting). Must be < `REFRESH_DIV`; 0 disables blanking.
- `Clk`, in, 1: system clock. One clock only.
- `Rst_n`, in, 1: asynchronous, active-low reset.
- `Value`, in, 16: value to display. Digit 3 = `Value[15:12]` (leftmost), digit 0 = `Value[3:0]`.
- `Dp_In`, in, 4: decimal-point request per digit, active-high. Sampled with `Value`.
- `Load`, in, 1: one-cycle strobe that captures `Value`/`Dp_In`.
- `Blank_Lead`, in, 1: enables leading-zero suppression. Live, not captured.
- `Digit_En`, in, 4: per-digit enable mask, active-high. Live.
- `Nibble`, out, 4: hex code for the current digit, to the decoder.
- `An`, out, 4: digit anodes, active-low; one-hot-low or all high.
- `Dp`, out, 1: decimal point, active-low.
- `Digit_Idx`, out, 2: current slot index.
- `Frame_Tick`, out, 1: one-cycle pulse at each frame start.

## Operation
- Prescaler `cnt` counts 0..`REFRESH_DIV`-1 and wraps to 0.
- Terminal count = cycle with `cnt == REFRESH_DIV-1`. On terminal count, `Digit_Idx` advances 3→2→1→0→3 (scan starts at the leftmost digit).
- Frame boundary = terminal count while `Digit_Idx == 0`. The next cycle starts digit 3 and `Frame_Tick` is 1 for exactly that cycle.
- Double buffer: `pend` (16+4 bits, plus `pend_v` flag) and `disp` (16+4 bits).
  - `Load` writes `pend` and sets `pend_v`.
  - At a frame boundary with `pend_v`=1: `disp ← pend`, `pend_v` cleared.
  - `Load` coincident with a boundary: the new `Value`/`Dp_In` go directly to `disp` and `pend_v` is cleared, so the newest value wins.
  - Back-to-back `Load`s within a frame: last one wins.
- Suppression (`Blank_Lead`=1), evaluated on `disp`:
  - Digit 3 is blank if its nibble is 0.
  - Digit 2 is blank if digits 3 and 2 are both 0.
  - Digit 1 is blank if digits 3..1 are all 0.
  - Digit 0 is never suppressed.
  - A set `Dp_In` bit on a digit overrides suppression for that digit only.
- Anode for slot `i`:
  - `An[i]` = 0 only when `cnt ≥ BLANK_CYCLES` and `Digit_En[i]` = 1 and the digit is not suppressed.
  - Otherwise `An` = 4'b1111.
  - A disabled or suppressed digit still consumes its slot, so brightness stays uniform.
- `Dp` = ~(`disp.dp[i]`) while `An[i]` = 0; otherwise 1.
- `Nibble` = `disp` nibble `i`. It is valid the whole slot, including the blank window, so the decoder settles before the anode turns on.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset values: `cnt`=0, `Digit_Idx`=3, `Nibble`=0, `An`=4'b1111, `Dp`=1, `Frame_Tick`=0, `disp`=0, `pend`=0, `pend_v`=0.
- First anode assertion: `An`=4'b0111 at cycle `BLANK_CYCLES` after reset release, provided `Digit_En[3]`=1 and `Blank_Lead`=0.
- On the cycle after terminal count:
  - `Digit_Idx`, `Nibble` and `An` (forced to 4'b1111 when `BLANK_CYCLES` > 0) update together.
  - The anode asserts `BLANK_CYCLES` cycles later.
  - With `BLANK_CYCLES`=0, `An` switches directly between one-hot values.
- `Load` → display latency: the next frame start. Worst case 4·`REFRESH_DIV` cycles; best case 1 cycle (coincident with a boundary).
- `Rst_n` low mid-slot: all state returns to reset values immediately (asynchronously). Scan restarts at digit 3 with `cnt`=0. Pending loads are discarded.
- `Blank_Lead`, `Digit_En` changes: take effect on `An` the next cycle.

## Test plan
Bench parameters: `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- **Reset/scan:** release reset, `Load` 16'h1234, all digits enabled.
  - After the first boundary, per 8-cycle slot: `Nibble` 1,2,3,4.
  - `An` 1111 for 2 cycles, then 0111 / 1011 / 1101 / 1110 for 6 cycles each.
  - `Frame_Tick` every 32 cycles.
- **Tear-free update:** `Load` 16'hABCD mid-slot of digit 2.
  - `Nibble` stays on the old value until `Frame_Tick`.
  - Then A,B,C,D.
- **Coincident/repeated load:**
  - `Load` 16'h00F0 on a boundary cycle → shown in the frame starting the next cycle.
  - Two `Load`s 16'h1111 then 16'h2222 in one frame → only 2222 is shown.
- **Suppression:** `disp`=16'h0005, `Blank_Lead`=1 → `An` stays 1111 for slots 3,2,1; 1110 in slot 0.
  - Adding `Dp_In`=4'b0100 lights digit 2 (`An`=1011, `Dp`=0).
- **Mask:** `Digit_En`=4'b0101 → `An` asserts only in slots 2 and 0; slot period stays 8 cycles.
- **Async reset mid-slot:** pull `Rst_n` low at `cnt`=5 of slot 1 → same cycle `An`=1111, `Dp`=1, `Nibble`=0.
  - After release, digit 3 asserts at cycle 2.
